// File: rtl/piccolo_mix_seq.sv
// Piccolo F-function diffusion y = M*x over GF(2^4), one nibble product per cycle
// through an external shared combinational multiplier (mul_a * mul_b -> mul_res).
module piccolo_mix_seq #(
    parameter int NSTEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [3:0]  mul_res,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAST   = 4'(NSTEP - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    // Nibble 3 is the most significant nibble, so element 0 of x/y lives at index ~0 = 3.
    logic [3:0][3:0] xreg_q, xreg_d;
    logic [3:0][3:0] acc_q, acc_d;

    logic [1:0] row, col, diag;
    logic [3:0] coef;

    assign row  = cnt_q[3:2];
    assign col  = cnt_q[1:0];
    // M is circulant: each row is [2 3 1 1] rotated right by the row index.
    assign diag = col - row;

    always_comb begin
        case (diag)
            2'd0:    coef = 4'd2;
            2'd1:    coef = 4'd3;
            default: coef = 4'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xreg_d  = xreg_q;
        acc_d   = acc_q;
        mul_a   = 4'd0;
        mul_b   = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xreg_d  = in_data;
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                mul_a       = coef;
                mul_b       = xreg_q[~col];
                acc_d[~row] = acc_q[~row] ^ mul_res;
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            xreg_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xreg_q  <= xreg_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign out_data  = acc_q;
endmodule

// File: tb/tb_piccolo_mix_seq.sv
// Directed bench for piccolo_mix_seq; the shared GF(2^4) multiplier is modelled here.
module tb_piccolo_mix_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  mul_a, mul_b, mul_res;
    logic        busy;

    int vec = 0;
    int err = 0;

    piccolo_mix_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = t[3] ? ({t[2:0], 1'b0} ^ 4'h3) : {t[2:0], 1'b0};
        end
        return p;
    endfunction

    always_comb mul_res = gf_mul(mul_a, mul_b);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until out_valid, bounded; returns edges taken after the accept edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    // Accept x, check latency and result, then complete the output handshake.
    task automatic run_word(input string tag, input logic [15:0] x, input logic [15:0] exp);
        int n;
        chk({tag, ".rdy"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_data  = x;
        step();
        in_valid = 1'b0;
        chk({tag, ".busy"}, 16'(busy), 16'd1);
        wait_valid(n);
        // out_valid is seen after the 16th edge past accept, i.e. during cycle 17
        chk({tag, ".lat"}, 16'(n), 16'd16);
        chk({tag, ".data"}, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".ovld0"}, 16'(out_valid), 16'd0);
        chk({tag, ".idle"}, 16'(in_ready), 16'd1);
    endtask

    logic [3:0] exp_a [16] = '{4'd2, 4'd3, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd1,
                               4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd1, 4'd1, 4'd2};

    initial begin
        int n;
        logic [3:0] eb;

        // reset state
        step();
        step();
        rst = 1'b0;
        chk("rst.in_ready", 16'(in_ready), 16'd1);
        chk("rst.out_valid", 16'(out_valid), 16'd0);
        chk("rst.out_data", out_data, 16'h0);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.mul_a", 16'(mul_a), 16'd0);
        chk("rst.mul_b", 16'(mul_b), 16'd0);

        // main function
        run_word("w1000", 16'h1000, 16'h2113);
        run_word("w0001", 16'h0001, 16'h1132);
        run_word("wFFFF", 16'hFFFF, 16'hFFFF);
        run_word("w8000", 16'h8000, 16'h388B);

        // back-pressure in DONE with an ignored in_valid pulse
        in_valid = 1'b1;
        in_data  = 16'h2000;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        chk("bp.lat", 16'(n), 16'd16);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                in_valid = 1'b1;
                in_data  = 16'h0001;
            end
            step();
            in_valid = 1'b0;
            chk("bp.ovld", 16'(out_valid), 16'd1);
            chk("bp.data", out_data, 16'h4226);
            chk("bp.in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.ovld0", 16'(out_valid), 16'd0);
        chk("bp.busy0", 16'(busy), 16'd0);
        run_word("bp.next", 16'h0001, 16'h1132);

        // reset during CALC at step 7
        in_valid = 1'b1;
        in_data  = 16'h1000;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("mid.busy", 16'(busy), 16'd1);
        chk("mid.step7.mul_a", 16'(mul_a), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid.in_ready", 16'(in_ready), 16'd1);
        chk("mid.out_valid", 16'(out_valid), 16'd0);
        chk("mid.busy0", 16'(busy), 16'd0);
        chk("mid.acc", out_data, 16'h0);
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid) chk("mid.no_result", 16'(out_valid), 16'd0);
        end
        run_word("mid.w1000", 16'h1000, 16'h2113);

        // operand trace for 0x1234: y = [3 4 9 A]
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            eb = 4'(i % 4 + 1);
            chk($sformatf("tr.a%0d", i), 16'(mul_a), 16'(exp_a[i]));
            chk($sformatf("tr.b%0d", i), 16'(mul_b), 16'(eb));
            step();
        end
        chk("tr.ovld", 16'(out_valid), 16'd1);
        chk("tr.data", out_data, 16'h349A);
        chk("tr.done.mul_a", 16'(mul_a), 16'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("tr.idle", 16'(in_ready), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
